porta_latch_ctrl: RTL and testbench

//   PORTA output-latch and TRISA direction register for the PIC16F84 core.

---
 rtl/porta_pkg.sv | 16 +
 rtl/porta_sync2.sv | 27 ++
 rtl/porta_latch_ctrl.sv | 109 ++++++++++
 tb/tb_porta_latch_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/porta_pkg.sv
// Shared constants and types for the PIC16F84 PORTA/TRISA register block.
package porta_pkg;

    localparam int              RA_W       = 5;
    localparam logic [7:0]      PORTA_ADDR = 8'h05;
    localparam logic [7:0]      TRISA_ADDR = 8'h85;
    localparam logic [RA_W-1:0] TRIS_RST   = 5'h1F;

    typedef logic [RA_W-1:0] ra_t;

    // Widen an RA-sized value onto the 8-bit core data bus.
    function automatic logic [7:0] ra_to_bus(input ra_t v);
        return {3'b000, v};
    endfunction

endpackage

// File: rtl/porta_sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous reset to zero.
module porta_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture of the asynchronous inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/porta_latch_ctrl.sv
// PORTA output latch, TRISA direction register and RA pin readback for the PIC16F84 core.
// Define PORTA_T0CKI_EN to build the RA4/T0CKI edge-tick generator for TMR0.
module porta_latch_ctrl
    import porta_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic [4:0]  pin_in,
    output logic [4:0]  data_out,
    output logic [4:0]  tris_out,
    input  logic        t0se,
    output logic        t0cki_tick
);

    ra_t        latch_r;
    ra_t        tris_r;
    ra_t        pin_sync_s;
    logic [7:0] rd_data_r;
    logic       rd_valid_r;
    logic [7:0] rd_mux_s;
    logic [2:0] unused_wr_hi_s;

    assign unused_wr_hi_s = wr_data[7:RA_W];

    porta_sync2 #(
        .W (RA_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_in),
        .q   (pin_sync_s)
    );

    // PORTA reads the synchronised pins rather than the latch, so core read-modify-write acts on pin levels.
    always_comb begin
        rd_mux_s = 8'h00;
        case (addr)
            PORTA_ADDR: rd_mux_s = ra_to_bus(pin_sync_s);
            TRISA_ADDR: rd_mux_s = ra_to_bus(tris_r);
            default:    rd_mux_s = 8'h00;
        endcase
    end

    // Register-file writes and registered read port; a same-cycle read sees the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_r    <= 5'h00;
            tris_r     <= TRIS_RST;
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_en && (addr == PORTA_ADDR)) begin
                latch_r <= wr_data[RA_W-1:0];
            end
            if (wr_en && (addr == TRISA_ADDR)) begin
                tris_r <= wr_data[RA_W-1:0];
            end
            if (rd_en) begin
                rd_data_r <= rd_mux_s;
            end
            rd_valid_r <= rd_en;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign tris_out = tris_r;
    assign data_out = latch_r & ~tris_r;

`ifdef PORTA_T0CKI_EN
    logic ra4_prev_r;
    logic tick_r;
    logic edge_s;

    // Selected-edge detect on the synchronised RA4, independent of its direction bit.
    always_comb begin
        if (t0se) begin
            edge_s = ~pin_sync_s[4] & ra4_prev_r;
        end else begin
            edge_s = pin_sync_s[4] & ~ra4_prev_r;
        end
    end

    // Previous-RA4 history and registered tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra4_prev_r <= 1'b0;
            tick_r     <= 1'b0;
        end else begin
            ra4_prev_r <= pin_sync_s[4];
            tick_r     <= edge_s;
        end
    end

    assign t0cki_tick = tick_r;
`else
    logic unused_t0se_s;

    assign unused_t0se_s = t0se;
    assign t0cki_tick    = 1'b0;
`endif

endmodule

// File: tb/tb_porta_latch_ctrl.sv
// Self-checking bench for porta_latch_ctrl: directed vector table, tick sequences, randomized model run.
module tb_porta_latch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] pin_in;
    logic [4:0] data_out;
    logic [4:0] tris_out;
    logic       t0se;
    logic       t0cki_tick;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PORTA_T0CKI_EN
    localparam bit TICK_BUILD = 1'b1;
`else
    localparam bit TICK_BUILD = 1'b0;
`endif

    porta_latch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .pin_in     (pin_in),
        .data_out   (data_out),
        .tris_out   (tris_out),
        .t0se       (t0se),
        .t0cki_tick (t0cki_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic       rd;
        logic [4:0] pin;
        logic [4:0] exp_dout;
        logic [4:0] exp_tris;
        logic       exp_rdv;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [18];

    // Reference-model state: register contents, read port, and recent pin history.
    logic [4:0] m_latch;
    logic [4:0] m_tris;
    logic [7:0] m_rdd;
    logic       m_rdv;
    logic [4:0] ph [3];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic w, input logic [7:0] wd,
                         input logic r, input logic [4:0] p);
        addr    = a;
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        pin_in  = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(8'h00, 1'b0, 8'h00, 1'b0, 5'h00);
        t0se = 1'b0;
        rst  = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_latch = 5'h00;
        m_tris  = 5'h1F;
        m_rdd   = 8'h00;
        m_rdv   = 1'b0;
        for (int i = 0; i < 3; i++) ph[i] = 5'h00;
    endtask

    // One RA4 edge in each direction; the tick is expected on the third edge after the pin moves.
    task automatic tick_seq(input logic sel);
        logic exp_rise;
        logic exp_fall;
        exp_rise = TICK_BUILD && !sel;
        exp_fall = TICK_BUILD && sel;
        t0se = sel;
        drive(8'h00, 1'b0, 8'h00, 1'b0, 5'h00);
        for (int j = 0; j < 5; j++) step();
        pin_in = 5'h10;
        for (int j = 0; j < 6; j++) begin
            step();
            chk(sel ? "tick_rise_fsel" : "tick_rise_rsel", {7'h00, t0cki_tick},
                {7'h00, (exp_rise && (j == 2))});
        end
        pin_in = 5'h00;
        for (int j = 0; j < 6; j++) begin
            step();
            chk(sel ? "tick_fall_fsel" : "tick_fall_rsel", {7'h00, t0cki_tick},
                {7'h00, (exp_fall && (j == 2))});
        end
    endtask

    initial begin
        logic [4:0] sync_now;
        logic [4:0] prev_now;
        logic       exp_tick;
        logic [4:0] p;

        vecs[0]  = '{8'h85, 1'b0, 8'h00, 1'b1, 5'h00, 5'h00, 5'h1F, 1'b1, 8'h1F};
        vecs[1]  = '{8'h85, 1'b1, 8'hF0, 1'b0, 5'h00, 5'h00, 5'h10, 1'b0, 8'h1F};
        vecs[2]  = '{8'h05, 1'b1, 8'hFF, 1'b0, 5'h15, 5'h0F, 5'h10, 1'b0, 8'h1F};
        vecs[3]  = '{8'h00, 1'b0, 8'h00, 1'b0, 5'h15, 5'h0F, 5'h10, 1'b0, 8'h1F};
        vecs[4]  = '{8'h05, 1'b0, 8'h00, 1'b1, 5'h15, 5'h0F, 5'h10, 1'b1, 8'h15};
        vecs[5]  = '{8'h85, 1'b1, 8'h1F, 1'b0, 5'h15, 5'h00, 5'h1F, 1'b0, 8'h15};
        vecs[6]  = '{8'h85, 1'b1, 8'h00, 1'b0, 5'h15, 5'h1F, 5'h00, 1'b0, 8'h15};
        vecs[7]  = '{8'h85, 1'b1, 8'h1F, 1'b0, 5'h15, 5'h00, 5'h1F, 1'b0, 8'h15};
        vecs[8]  = '{8'h85, 1'b1, 8'h03, 1'b1, 5'h15, 5'h1C, 5'h03, 1'b1, 8'h1F};
        vecs[9]  = '{8'h85, 1'b0, 8'h00, 1'b1, 5'h15, 5'h1C, 5'h03, 1'b1, 8'h03};
        vecs[10] = '{8'h00, 1'b0, 8'h00, 1'b0, 5'h00, 5'h1C, 5'h03, 1'b0, 8'h03};
        vecs[11] = '{8'h00, 1'b0, 8'h00, 1'b0, 5'h00, 5'h1C, 5'h03, 1'b0, 8'h03};
        vecs[12] = '{8'h05, 1'b0, 8'h00, 1'b1, 5'h1F, 5'h1C, 5'h03, 1'b1, 8'h00};
        vecs[13] = '{8'h05, 1'b0, 8'h00, 1'b1, 5'h1F, 5'h1C, 5'h03, 1'b1, 8'h00};
        vecs[14] = '{8'h05, 1'b0, 8'h00, 1'b1, 5'h1F, 5'h1C, 5'h03, 1'b1, 8'h1F};
        vecs[15] = '{8'h33, 1'b0, 8'h00, 1'b1, 5'h1F, 5'h1C, 5'h03, 1'b1, 8'h00};
        vecs[16] = '{8'h06, 1'b1, 8'hFF, 1'b0, 5'h1F, 5'h1C, 5'h03, 1'b0, 8'h00};
        vecs[17] = '{8'h05, 1'b1, 8'h00, 1'b1, 5'h1F, 5'h00, 5'h03, 1'b1, 8'h1F};

        do_reset();
        chk("reset_data_out", {3'b000, data_out}, 8'h00);
        chk("reset_tris_out", {3'b000, tris_out}, 8'h1F);
        chk("reset_rd_valid", {7'h00, rd_valid}, 8'h00);
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_tick", {7'h00, t0cki_tick}, 8'h00);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rd, vecs[i].pin);
            step();
            chk($sformatf("vec%0d_data_out", i), {3'b000, data_out}, {3'b000, vecs[i].exp_dout});
            chk($sformatf("vec%0d_tris_out", i), {3'b000, tris_out}, {3'b000, vecs[i].exp_tris});
            chk($sformatf("vec%0d_rd_valid", i), {7'h00, rd_valid}, {7'h00, vecs[i].exp_rdv});
            chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
        end

        // Reset asserted while a read result is being presented.
        drive(8'h85, 1'b0, 8'h00, 1'b1, 5'h00);
        step();
        chk("midread_valid_before", {7'h00, rd_valid}, 8'h01);
        rst = 1'b1;
        #1;
        chk("midread_valid_after_rst", {7'h00, rd_valid}, 8'h00);
        chk("midread_tris_after_rst", {3'b000, tris_out}, 8'h1F);
        do_reset();

        tick_seq(1'b0);
        tick_seq(1'b1);

        // Randomized traffic against the reference model.
        do_reset();
        p = 5'h00;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       addr = 8'h05;
                1:       addr = 8'h85;
                2:       addr = 8'h85;
                default: addr = 8'($urandom);
            endcase
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom);
            if ($urandom_range(0, 3) == 0) p = 5'($urandom);
            pin_in = p;
            if ($urandom_range(0, 15) == 0) t0se = ~t0se;

            // The core sees the pin level from two edges ago; the tick compares it with three edges ago.
            sync_now = ph[1];
            prev_now = ph[2];
            exp_tick = TICK_BUILD && (t0se ? (!sync_now[4] && prev_now[4])
                                           : (sync_now[4] && !prev_now[4]));
            m_rdv = rd_en;
            if (rd_en) begin
                if (addr == 8'h05)      m_rdd = {3'b000, sync_now};
                else if (addr == 8'h85) m_rdd = {3'b000, m_tris};
                else                    m_rdd = 8'h00;
            end
            if (wr_en && addr == 8'h05) m_latch = wr_data[4:0];
            if (wr_en && addr == 8'h85) m_tris = wr_data[4:0];
            ph[2] = ph[1];
            ph[1] = ph[0];
            ph[0] = pin_in;

            step();
            chk("rnd_data_out", {3'b000, data_out}, {3'b000, m_latch & ~m_tris});
            chk("rnd_tris_out", {3'b000, tris_out}, {3'b000, m_tris});
            chk("rnd_rd_valid", {7'h00, rd_valid}, {7'h00, m_rdv});
            chk("rnd_rd_data", rd_data, m_rdd);
            chk("rnd_tick", {7'h00, t0cki_tick}, {7'h00, exp_tick});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
